multiplier_pipe_param: RTL

MULTIPLIER_PIPE_PARAM -- requirements
Module: multiplier_pipe_param

---
 rtl/multiplier_pipe_param.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/multiplier_pipe_param.sv
// Pipelined signed/unsigned multiplier with a start/stop session controller.
// Operands are extended to 2*WIDTH bits (sign or zero, per operation) and the
// product is accumulated two multiplier bits per stage over WIDTH stages, then
// registered into the result/out_vld output slot. A stalled output freezes the
// whole pipe.
module multiplier_pipe_param #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_signed,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic               mul_start,
    input  logic               mul_stop,
    output logic [2*WIDTH-1:0] result,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic               pipe_done,
    output logic               busy,
    output logic [CNT_W-1:0]   op_cnt
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef logic [PW-1:0] word_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e           state_q, state_d;

    // Operand words only need to travel to the second-to-last stage; the last
    // stage adds its partial products straight into the accumulator.
    word_t            a_q   [WIDTH-1];
    word_t            b_q   [WIDTH-1];
    word_t            a_d   [WIDTH-1];
    word_t            b_d   [WIDTH-1];
    word_t            acc_q [WIDTH];
    word_t            acc_d [WIDTH];
    logic [WIDTH-1:0] vld_q, vld_d;

    logic             out_vld_q;
    word_t            result_q;
    logic             pipe_done_q;
    logic [CNT_W-1:0] op_cnt_q;

    logic             stall;
    logic             xfer;
    logic             pipe_empty;
    word_t            a_ext;
    word_t            b_ext;

    // Sum of the partial products for multiplier bits 2j and 2j+1.
    function automatic word_t partial_sum(input word_t x, input word_t y, input int unsigned j);
        word_t sum;
        sum = '0;
        if (((y >> (2 * j)) & word_t'(1)) != '0) begin
            sum = sum + (x << (2 * j));
        end
        if (((y >> (2 * j + 1)) & word_t'(1)) != '0) begin
            sum = sum + (x << (2 * j + 1));
        end
        return sum;
    endfunction

    assign stall      = out_vld_q & ~out_rdy;
    assign in_rdy     = (state_q == StRun) & ~stall;
    assign xfer       = in_vld & in_rdy;
    assign pipe_empty = ~|vld_q & ~out_vld_q;

    // Extend operands so the 2*WIDTH-bit modular product is exact in both modes.
    always_comb begin
        a_ext = {{WIDTH{in_signed & a[WIDTH-1]}}, a};
        b_ext = {{WIDTH{in_signed & b[WIDTH-1]}}, b};
    end

    // Session control: start opens, stop closes, drain waits for an empty pipe.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (mul_start && !mul_stop) state_d = StRun;
            StRun:   if (mul_stop) state_d = StDrain;
            StDrain: if (pipe_empty) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state of the pipeline stages; everything holds while stalled.
    always_comb begin
        vld_d = vld_q;
        for (int j = 0; j < WIDTH - 1; j++) begin
            a_d[j] = a_q[j];
            b_d[j] = b_q[j];
        end
        for (int j = 0; j < WIDTH; j++) begin
            acc_d[j] = acc_q[j];
        end
        if (!stall) begin
            vld_d[0] = xfer;
            a_d[0]   = a_ext;
            b_d[0]   = b_ext;
            acc_d[0] = partial_sum(a_ext, b_ext, 0);
            for (int j = 1; j < WIDTH - 1; j++) begin
                a_d[j] = a_q[j-1];
                b_d[j] = b_q[j-1];
            end
            for (int j = 1; j < WIDTH; j++) begin
                vld_d[j] = vld_q[j-1];
                acc_d[j] = acc_q[j-1] + partial_sum(a_q[j-1], b_q[j-1], j);
            end
        end
    end

    // Pipeline stage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int j = 0; j < WIDTH - 1; j++) begin
                a_q[j] <= '0;
                b_q[j] <= '0;
            end
            for (int j = 0; j < WIDTH; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int j = 0; j < WIDTH - 1; j++) begin
                a_q[j] <= a_d[j];
                b_q[j] <= b_d[j];
            end
            for (int j = 0; j < WIDTH; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    // Output slot: result only moves when a valid product arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            result_q  <= '0;
        end else if (!stall) begin
            out_vld_q <= vld_q[WIDTH-1];
            if (vld_q[WIDTH-1]) begin
                result_q <= acc_q[WIDTH-1];
            end
        end
    end

    // Per-session saturating transfer counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_cnt_q <= '0;
        end else if (state_q == StIdle && state_d == StRun) begin
            op_cnt_q <= '0;
        end else if (xfer && op_cnt_q != '1) begin
            op_cnt_q <= op_cnt_q + CNT_W'(1);
        end
    end

    // Drain-complete pulse, high for the first cycle back in idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_done_q <= 1'b0;
        end else begin
            pipe_done_q <= (state_q == StDrain) && (state_d == StIdle);
        end
    end

    assign result    = result_q;
    assign out_vld   = out_vld_q;
    assign pipe_done = pipe_done_q;
    assign busy      = (state_q != StIdle);
    assign op_cnt    = op_cnt_q;

endmodule
